// File: rtl/capture_limiter.sv
// Run/stop controller for the logic-analyzer sample path: counts accepted sample strobes
// and ends a capture in free-run, fixed-count or pre/post-trigger mode.
module capture_limiter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_trigger,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_limit,
  input  logic [CNT_W-1:0] i_pre_limit,
  output logic             o_stop,
  output logic             o_done,
  output logic             o_triggered,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_count,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPre      = 3'd1,
    StWaitTrig = 3'd2,
    StPost     = 3'd3,
    StStop     = 3'd4
  } state_e;

  localparam logic [1:0]       ModeCount = 2'd1;
  localparam logic [1:0]       ModeTrig  = 2'd2;
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] limit_q, pre_limit_q, count_q, pre_cnt_q;
  logic             trig_q, sat_q, stop_q, done_q;
  logic [CNT_W-1:0] count_inc, pre_inc;
  logic             limited;

  assign count_inc = count_q + CntOne;
  assign pre_inc   = pre_cnt_q + CntOne;
  // Reserved mode 3 behaves as FREE, so only COUNT and TRIGGERED honour the limit.
  assign limited   = (mode_q == ModeCount) || (mode_q == ModeTrig);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      limit_q     <= '0;
      pre_limit_q <= '0;
      count_q     <= '0;
      pre_cnt_q   <= '0;
      trig_q      <= 1'b0;
      sat_q       <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && !i_run) begin
        // Abort: count and trigger flag are kept for readback.
        state_q <= StIdle;
        stop_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_run) begin
              mode_q      <= i_mode;
              limit_q     <= i_limit;
              pre_limit_q <= i_pre_limit;
              count_q     <= '0;
              pre_cnt_q   <= '0;
              trig_q      <= 1'b0;
              sat_q       <= 1'b0;
              if (i_mode == ModeCount) begin
                if (i_limit == '0) begin
                  state_q <= StStop;
                  stop_q  <= 1'b1;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= StPost;
                end
              end else if (i_mode == ModeTrig) begin
                state_q <= (i_pre_limit == '0) ? StWaitTrig : StPre;
              end else begin
                state_q <= StPost;
              end
            end
          end
          StPre: begin
            if (i_step) begin
              pre_cnt_q <= pre_inc;
              if (pre_inc == pre_limit_q) state_q <= StWaitTrig;
            end
          end
          StWaitTrig: begin
            if (i_step && i_trigger) begin
              trig_q  <= 1'b1;
              count_q <= CntOne;
              if (limit_q <= CntOne) begin
                state_q <= StStop;
                stop_q  <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                state_q <= StPost;
              end
            end
          end
          StPost: begin
            if (i_step) begin
              if (limited) begin
                count_q <= count_inc;
                if (count_inc == limit_q) begin
                  state_q <= StStop;
                  stop_q  <= 1'b1;
                  done_q  <= 1'b1;
                end
              end else if (count_q != CntMax) begin
                count_q <= count_inc;
                if (count_inc == CntMax) sat_q <= 1'b1;
              end
            end
          end
          StStop: begin
          end
          default: begin
            state_q <= StIdle;
            stop_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_stop      = stop_q;
  assign o_done      = done_q;
  assign o_triggered = trig_q;
  assign o_sat       = sat_q;
  assign o_count     = count_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_capture_limiter.sv
// Self-checking bench for capture_limiter: directed scenarios plus a randomized run
// against a behavioural model of the capture rules.
module tb_capture_limiter;

  localparam int W = 4;
  localparam int MaxCnt = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0, step = 1'b0, trigger = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] limit = '0, pre_limit = '0;
  logic         stop, done, triggered, sat;
  logic [W-1:0] count;
  logic [2:0]   state;

  int errors = 0;
  int checks = 0;

  capture_limiter #(.CNT_W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .i_step      (step),
    .i_trigger   (trigger),
    .i_mode      (mode),
    .i_limit     (limit),
    .i_pre_limit (pre_limit),
    .o_stop      (stop),
    .o_done      (done),
    .o_triggered (triggered),
    .o_sat       (sat),
    .o_count     (count),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({state, count, stop, done, triggered, sat} !== {3'd0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset: state=%0d count=%0d stop=%b done=%b trig=%b sat=%b, want all 0",
               state, count, stop, done, triggered, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count5;
    mode = 2'd1; limit = 4'd5; run = 1'b1;
    tick();
    checks++;
    if (state !== 3'd3 || count !== 4'd0) begin
      errors++;
      $display("FAIL count5_arm: state=%0d count=%0d, want 3/0", state, count);
    end
    for (int i = 1; i <= 5; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (count !== 4'(i) || done !== (i == 5) || stop !== (i == 5)) begin
        errors++;
        $display("FAIL count5_step%0d: count=%0d done=%b stop=%b, want %0d/%b/%b",
                 i, count, done, stop, i, i == 5, i == 5);
      end
      tick();
    end
    checks++;
    if (done !== 1'b0 || stop !== 1'b1 || state !== 3'd4 || count !== 4'd5) begin
      errors++;
      $display("FAIL count5_hold: done=%b stop=%b state=%0d count=%0d, want 0/1/4/5",
               done, stop, state, count);
    end
    run = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || stop !== 1'b0 || count !== 4'd5) begin
      errors++;
      $display("FAIL count5_idle: state=%0d stop=%b count=%0d, want 0/0/5", state, stop, count);
    end
  endtask

  task automatic test_count0;
    mode = 2'd1; limit = 4'd0; run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || stop !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL count0_arm: state=%0d done=%b stop=%b count=%0d, want 4/1/1/0",
               state, done, stop, count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || stop !== 1'b1) begin
      errors++;
      $display("FAIL count0_pulse: done=%b stop=%b, want 0/1", done, stop);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_triggered;
    mode = 2'd2; pre_limit = 4'd3; limit = 4'd4; run = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL trig_arm: state=%0d, want 1", state);
    end
    step = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checks++;
    if (state !== 3'd1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL trig_pre_ignore: state=%0d trig=%b, want 1/0", state, triggered);
    end
    tick();
    tick();
    checks++;
    if (state !== 3'd2 || triggered !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL trig_wait: state=%0d trig=%b count=%0d, want 2/0/0",
               state, triggered, count);
    end
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checks++;
    if (state !== 3'd3 || triggered !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL trig_accept: state=%0d trig=%b count=%0d, want 3/1/1",
               state, triggered, count);
    end
    tick();
    tick();
    checks++;
    if (count !== 4'd3 || stop !== 1'b0) begin
      errors++;
      $display("FAIL trig_post: count=%0d stop=%b, want 3/0", count, stop);
    end
    tick();
    step = 1'b0;
    checks++;
    if (count !== 4'd4 || stop !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL trig_stop: count=%0d stop=%b done=%b, want 4/1/1", count, stop, done);
    end
    run = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || triggered !== 1'b1 || count !== 4'd4) begin
      errors++;
      $display("FAIL trig_abort_hold: state=%0d trig=%b count=%0d, want 0/1/4",
               state, triggered, count);
    end
  endtask

  task automatic test_trig_pre0;
    mode = 2'd2; pre_limit = 4'd0; limit = 4'd1; run = 1'b1;
    tick();
    checks++;
    if (state !== 3'd2 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL pre0_arm: state=%0d trig=%b, want 2/0", state, triggered);
    end
    step = 1'b1; trigger = 1'b1;
    tick();
    step = 1'b0; trigger = 1'b0;
    checks++;
    if (state !== 3'd4 || count !== 4'd1 || done !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL pre0_stop: state=%0d count=%0d done=%b trig=%b, want 4/1/1/1",
               state, count, done, triggered);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL pre0_pulse: done=%b, want 0", done);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_free;
    mode = 2'd0; limit = 4'd3; run = 1'b1;
    tick();
    step = 1'b1;
    repeat (20) tick();
    step = 1'b0;
    checks++;
    if (count !== 4'd15 || sat !== 1'b1 || stop !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL free_sat: count=%0d sat=%b stop=%b state=%0d, want 15/1/0/3",
               count, sat, stop, state);
    end
    run = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || count !== 4'd15) begin
      errors++;
      $display("FAIL free_idle: state=%0d count=%0d, want 0/15", state, count);
    end
  endtask

  task automatic test_abort_rearm;
    mode = 2'd1; limit = 4'd10; run = 1'b1;
    tick();
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0; run = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || stop !== 1'b0 || done !== 1'b0 || count !== 4'd3) begin
      errors++;
      $display("FAIL abort: state=%0d stop=%b done=%b count=%0d, want 0/0/0/3",
               state, stop, done, count);
    end
    limit = 4'd2; run = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || state !== 3'd3 || sat !== 1'b0) begin
      errors++;
      $display("FAIL rearm: count=%0d state=%0d sat=%b, want 0/3/0", count, state, sat);
    end
    // Inputs changed after arming must not affect the capture.
    mode = 2'd0; limit = 4'd9; step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    checks++;
    if (stop !== 1'b1 || count !== 4'd2) begin
      errors++;
      $display("FAIL latched_limit: stop=%b count=%0d, want 1/2", stop, count);
    end
    tick();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL no_rearm_in_stop: state=%0d, want 4", state);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pre;
    mode = 2'd2; pre_limit = 4'd5; limit = 4'd3; run = 1'b1;
    tick();
    step = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, count, stop, done, triggered, sat} !== {3'd0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_pre: state=%0d count=%0d stop=%b done=%b trig=%b sat=%b",
               state, count, stop, done, triggered, sat);
    end
    run = 1'b0; step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Model of the capture rules; phase uses the published o_state numbering.
  task automatic test_random;
    int ph = 0, cnt = 0, pre = 0, m_mode = 0, m_lim = 0, m_pre = 0;
    bit m_trig = 0, m_sat = 0, m_done = 0;
    for (int c = 0; c < 600; c++) begin
      run       = ($urandom_range(0, 24) != 0);
      step      = 1'($urandom_range(0, 1));
      trigger   = ($urandom_range(0, 3) == 0);
      mode      = 2'($urandom_range(0, 3));
      limit     = 4'($urandom_range(0, 6));
      pre_limit = 4'($urandom_range(0, 4));
      m_done = 0;
      if (!run) begin
        ph = 0;
      end else if (ph == 0) begin
        m_mode = mode; m_lim = limit; m_pre = pre_limit;
        cnt = 0; pre = 0; m_trig = 0; m_sat = 0;
        if (m_mode == 1) begin
          ph = (m_lim == 0) ? 4 : 3;
          m_done = (m_lim == 0);
        end else if (m_mode == 2) begin
          ph = (m_pre == 0) ? 2 : 1;
        end else begin
          ph = 3;
        end
      end else if (ph == 1) begin
        if (step) begin
          pre++;
          if (pre == m_pre) ph = 2;
        end
      end else if (ph == 2) begin
        if (step && trigger) begin
          m_trig = 1; cnt = 1;
          if (m_lim <= 1) begin ph = 4; m_done = 1; end
          else ph = 3;
        end
      end else if (ph == 3 && step) begin
        if (m_mode == 1 || m_mode == 2) begin
          cnt++;
          if (cnt == m_lim) begin ph = 4; m_done = 1; end
        end else begin
          if (cnt < MaxCnt) cnt++;
          if (cnt == MaxCnt) m_sat = 1;
        end
      end
      tick();
      checks++;
      if (state !== 3'(ph) || count !== 4'(cnt) || stop !== (ph == 4) || done !== m_done ||
          triggered !== m_trig || sat !== m_sat) begin
        errors++;
        $display("FAIL random_c%0d: st=%0d cnt=%0d stop=%b done=%b trig=%b sat=%b, want %0d/%0d/%b/%b/%b/%b",
                 c, state, count, stop, done, triggered, sat,
                 ph, cnt, ph == 4, m_done, m_trig, m_sat);
      end
    end
    run = 1'b0; step = 1'b0; trigger = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_count5();
    test_count0();
    test_triggered();
    test_trig_pre0();
    test_free();
    test_abort_rearm();
    test_reset_mid_pre();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
